// File: rtl/coin_collector_pkg.sv
// coin_collector_pkg: shared definitions for the ticket vending front end.
//   - FSM state encoding (IDLE / COLLECT / HOLD)
//   - ticket range and refund code
//   - coin face values, also consumed by the pricing/change stage
package coin_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int CNT_W     = 4;
    localparam int NUM_COINS = 3;

    localparam logic [3:0] TICKET_MIN    = 4'd2;
    localparam logic [3:0] TICKET_MAX    = 4'd10;
    localparam logic [3:0] TICKET_REFUND = 4'd0;

    localparam logic [3:0] COIN_ONE_VAL  = 4'd1;
    localparam logic [3:0] COIN_FIVE_VAL = 4'd5;
    localparam logic [3:0] COIN_TEN_VAL  = 4'd10;

    function automatic logic ticket_legal(input logic [3:0] t);
        return (t >= TICKET_MIN) && (t <= TICKET_MAX);
    endfunction

endpackage

// File: rtl/sat_counter4.sv
// sat_counter4: 4-bit saturating up-counter.
//   clk, rst_n : clock, async active-low reset
//   inc        : count request; ignored once the counter sits at MAX
//   clr        : synchronous clear, overrides inc
//   cnt        : current count
//   at_max     : count equals MAX (an inc this cycle is dropped)
module sat_counter4 #(
    parameter logic [3:0] MAX = 4'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       at_max
);

    assign at_max = (cnt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 4'd1;
    end

endmodule

// File: rtl/coin_collector.sv
// coin_collector: counts 1/5/10-yuan coins, latches the ticket choice and,
// on confirm / cancel / inactivity timeout, presents a frozen
// {one, five, ten, ticket} transaction until vend_ack.
//   clk, rst_n                  : clock, async active-low reset
//   coin_one/five/ten           : one-cycle coin pulses
//   sel_valid, ticket_sel       : ticket choice (legal 2..10)
//   confirm, cancel             : passenger buttons
//   vend_ack                    : downstream consumed the transaction
//   one, five, ten, ticket      : presented transaction (ticket 0 = refund)
//   vend_valid                  : transaction valid and stable
//   coin_reject                 : a coin was not counted (registered pulse)
//   busy                        : state is not IDLE
module coin_collector
    import coin_collector_pkg::*;
#(
    parameter int CNT_MAX        = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_one,
    input  logic       coin_five,
    input  logic       coin_ten,
    input  logic       sel_valid,
    input  logic [3:0] ticket_sel,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       vend_ack,
    output logic [3:0] one,
    output logic [3:0] five,
    output logic [3:0] ten,
    output logic [3:0] ticket,
    output logic       vend_valid,
    output logic       coin_reject,
    output logic       busy
);

    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t                           state, state_d;
    logic [NUM_COINS-1:0]             coin_in, coin_inc, at_max;
    logic [NUM_COINS-1:0][CNT_W-1:0]  cnt;
    logic [3:0]                       ticket_lat;
    logic [TMR_W-1:0]                 timer;

    logic accepting, sel_ok, activity, do_ack;
    logic go_cancel, go_confirm, go_timeout;

    assign coin_in   = {coin_ten, coin_five, coin_one};
    assign accepting = (state != HOLD);
    assign sel_ok    = sel_valid && ticket_legal(ticket_sel);
    // Any coin pulse counts as activity, even one rejected at saturation.
    assign activity  = (|coin_in) || sel_ok;
    assign do_ack    = (state == HOLD) && vend_ack;

    assign go_cancel  = (state == COLLECT) && cancel;
    // The latch only ever holds legal values, so non-zero means "chosen".
    assign go_confirm = (state == COLLECT) && confirm && !cancel &&
                        (ticket_lat != TICKET_REFUND);
    // A coin or selection on the last idle cycle reloads the timer instead.
    assign go_timeout = (state == COLLECT) && !activity && (timer == TMR_LAST);

    assign coin_inc = accepting ? coin_in : '0;

    // Lane 0 = 1-yuan, lane 1 = 5-yuan, lane 2 = 10-yuan.
    for (genvar g = 0; g < NUM_COINS; g++) begin : g_cnt
        sat_counter4 #(.MAX(4'(CNT_MAX))) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (coin_inc[g]),
            .clr    (do_ack),
            .cnt    (cnt[g]),
            .at_max (at_max[g])
        );
    end

    assign one  = cnt[0];
    assign five = cnt[1];
    assign ten  = cnt[2];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (activity) state_d = COLLECT;
            COLLECT: if (go_cancel || go_confirm || go_timeout) state_d = HOLD;
            HOLD:    if (vend_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != IDLE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ticket_lat  <= TICKET_REFUND;
            timer       <= '0;
            ticket      <= TICKET_REFUND;
            vend_valid  <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            if (do_ack)
                ticket_lat <= TICKET_REFUND;
            else if (accepting && sel_ok)
                ticket_lat <= ticket_sel;

            // Timer runs only while staying in COLLECT with no activity,
            // so it is zero on every entry to and exit from COLLECT.
            if ((state == COLLECT) && (state_d == COLLECT) && !activity)
                timer <= timer + 1'b1;
            else
                timer <= '0;

            if ((state == COLLECT) && (state_d == HOLD))
                ticket <= go_confirm ? ticket_lat : TICKET_REFUND;
            else if (do_ack)
                ticket <= TICKET_REFUND;

            vend_valid  <= (state_d == HOLD);
            coin_reject <= |(coin_in & (accepting ? at_max : '1));
        end
    end

endmodule

// File: tb/tb_coin_collector.sv
module tb_coin_collector;

    localparam int TMO = 20;

    typedef struct {
        logic       c1, c5, c10, sv;
        logic [3:0] sel;
        logic       cf, cn, ack;
        logic [3:0] e_one, e_five, e_ten, e_tk;
        logic       e_vv, e_busy, e_rej;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_one = 0, coin_five = 0, coin_ten = 0, sel_valid = 0;
    logic [3:0] ticket_sel = '0;
    logic       confirm = 0, cancel = 0, vend_ack = 0;
    logic [3:0] one, five, ten, ticket;
    logic       vend_valid, coin_reject, busy;

    int passed = 0;
    int total  = 0;

    logic [18:0] exp_q[$];
    vec_t        tbl[$];

    coin_collector #(.CNT_MAX(15), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_one(coin_one), .coin_five(coin_five), .coin_ten(coin_ten),
        .sel_valid(sel_valid), .ticket_sel(ticket_sel),
        .confirm(confirm), .cancel(cancel), .vend_ack(vend_ack),
        .one(one), .five(five), .ten(ten), .ticket(ticket),
        .vend_valid(vend_valid), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [18:0] obs = {one, five, ten, ticket, vend_valid, busy, coin_reject};

    function automatic vec_t mk(input logic c1, c5, c10, sv, input int sel,
                                input logic cf, cn, ack,
                                input int o, f, t, tk, input logic vv, bz, rj);
        vec_t v;
        v.c1 = c1; v.c5 = c5; v.c10 = c10; v.sv = sv; v.sel = 4'(sel);
        v.cf = cf; v.cn = cn; v.ack = ack;
        v.e_one = 4'(o); v.e_five = 4'(f); v.e_ten = 4'(t); v.e_tk = 4'(tk);
        v.e_vv = vv; v.e_busy = bz; v.e_rej = rj;
        return v;
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got {one,five,ten,ticket,vv,busy,rej}=%0d,%0d,%0d,%0d,%b,%b,%b want %0d,%0d,%0d,%0d,%b,%b,%b",
                      name, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                      want[18:15], want[14:11], want[10:7], want[6:3], want[2], want[1], want[0]);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic run(input vec_t v, input string name);
        logic [18:0] e;
        @(negedge clk);
        coin_one = v.c1; coin_five = v.c5; coin_ten = v.c10;
        sel_valid = v.sv; ticket_sel = v.sel;
        confirm = v.cf; cancel = v.cn; vend_ack = v.ack;
        exp_q.push_back({v.e_one, v.e_five, v.e_ten, v.e_tk, v.e_vv, v.e_busy, v.e_rej});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, obs, e);
        coin_one = 0; coin_five = 0; coin_ten = 0; sel_valid = 0;
        ticket_sel = '0; confirm = 0; cancel = 0; vend_ack = 0;
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check(name, obs, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //            c1 c5 c10 sv sel cf cn ack  one five ten tk vv bz rj
        // main purchase: 1+5 share a cycle, then 1, 10, sel 7, confirm
        tbl.push_back(mk(1,1,0,0, 0,0,0,0,  1,1,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,  2,1,0,0, 0,1,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,  2,1,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,1, 7,0,0,0,  2,1,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,1,0,0,  2,1,1,7, 1,1,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,  2,1,1,7, 1,1,1)); // coin in HOLD
        tbl.push_back(mk(0,0,0,1, 3,1,1,0,  2,1,1,7, 1,1,0)); // ignored in HOLD
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,  0,0,0,0, 0,0,0));
        // IDLE ignores confirm/cancel and illegal selections
        tbl.push_back(mk(0,0,0,0, 0,1,1,0,  0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,1,11,0,0,0,  0,0,0,0, 0,0,0));
        // illegal sel then confirm stays in COLLECT; sel 10 then confirm
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,  1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,1,11,0,0,0,  1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,1,0,0,  1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,1,10,0,0,0,  1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,1,0,0,  1,0,0,10,1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,  0,0,0,0, 0,0,0));
        // confirm + cancel together: cancel wins
        tbl.push_back(mk(0,1,0,0, 0,0,0,0,  0,1,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,1, 3,0,0,0,  0,1,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,1,1,0,  0,1,0,0, 1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,  0,0,0,0, 0,0,0));
        // ack outside HOLD ignored; sel 1 illegal; cancel refunds
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,  0,0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,  0,0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,1, 1,0,0,0,  0,0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,1,0,0,  0,0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,1,0,  0,0,1,0, 1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,  0,0,0,0, 0,0,0));
        // legal sel alone leaves IDLE; minimum ticket
        tbl.push_back(mk(0,0,0,1, 2,0,0,0,  0,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,1,0,0,  0,0,0,2, 1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,  0,0,0,0, 0,0,0));

        // reset state
        #1 check("reset_state", obs, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i));

        // saturation: 16 coin_one pulses, reject only on the 16th
        for (int i = 0; i < 16; i++)
            run(mk(1,0,0,0, 0,0,0,0, (i < 15) ? i + 1 : 15, 0,0,0, 0,1, i == 15),
                $sformatf("sat%0d", i));
        run(mk(0,0,0,0, 0,0,0,0, 15,0,0,0, 0,1,0), "sat_idle");
        run(mk(1,1,0,0, 0,0,0,0, 15,1,0,0, 0,1,1), "sat_mixed");
        run(mk(0,0,0,0, 0,0,1,0, 15,1,0,0, 1,1,0), "sat_cancel");
        run(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 0,0,0), "sat_ack");

        // timeout after TMO idle cycles
        run(mk(0,0,1,0, 0,0,0,0, 0,0,1,0, 0,1,0), "tmo_coin");
        for (int i = 1; i < TMO; i++)
            run(mk(0,0,0,0, 0,0,0,0, 0,0,1,0, 0,1,0), $sformatf("tmo_wait%0d", i));
        run(mk(0,0,0,0, 0,0,0,0, 0,0,1,0, 1,1,0), "tmo_fire");
        run(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 0,0,0), "tmo_ack");

        // coin on the last idle cycle suppresses the timeout and restarts it
        run(mk(0,0,1,0, 0,0,0,0, 0,0,1,0, 0,1,0), "tmo2_coin");
        for (int i = 1; i < TMO; i++)
            run(mk(0,0,0,0, 0,0,0,0, 0,0,1,0, 0,1,0), $sformatf("tmo2_wait%0d", i));
        run(mk(1,0,0,0, 0,0,0,0, 1,0,1,0, 0,1,0), "tmo2_late_coin");
        for (int i = 1; i < TMO; i++)
            run(mk(0,0,0,0, 0,0,0,0, 1,0,1,0, 0,1,0), $sformatf("tmo2_rewait%0d", i));
        run(mk(0,0,0,0, 0,0,0,0, 1,0,1,0, 1,1,0), "tmo2_fire");
        run(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 0,0,0), "tmo2_ack");

        // async reset mid-COLLECT
        run(mk(1,0,1,0, 0,0,0,0, 1,0,1,0, 0,1,0), "rc_coin");
        async_reset("rst_collect");
        run(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0), "rc_after");

        // async reset mid-HOLD
        run(mk(0,1,0,0, 0,0,0,0, 0,1,0,0, 0,1,0), "rh_coin");
        run(mk(0,0,0,1, 5,0,0,0, 0,1,0,0, 0,1,0), "rh_sel");
        run(mk(0,0,0,0, 0,1,0,0, 0,1,0,5, 1,1,0), "rh_confirm");
        async_reset("rst_hold");
        run(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0), "rh_after");
        run(mk(1,0,0,0, 0,0,0,0, 1,0,0,0, 0,1,0), "rh_resume");
        run(mk(0,0,0,0, 0,1,0,0, 1,0,0,0, 0,1,0), "rh_no_ticket");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
